// File: rtl/camera_pixel_assembler.sv
// Assembles BYTES_PER_PIXEL camera bus words into one pixel, clocked entirely by clk_pixel_in.
// Optional macro CAM_ASSEMBLER_COORD_EN adds hcount_out/vcount_out pixel coordinates.
module camera_pixel_assembler #(
   parameter int IN_WIDTH        = 8,
   parameter int BYTES_PER_PIXEL = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int HMAX            = 2047,
   parameter int VMAX            = 1023
) (
   input  logic                                clk_pixel_in,
   input  logic                                rst_in,
   input  logic                                pclk_cam_in,
   input  logic                                hs_cam_in,
   input  logic                                vs_cam_in,
   input  logic [IN_WIDTH-1:0]                 data_cam_in,
   output logic [IN_WIDTH*BYTES_PER_PIXEL-1:0] data_out,
   output logic                                valid_out,
   output logic                                frame_start_out,
   output logic                                line_start_out,
   output logic                                partial_out,
`ifdef CAM_ASSEMBLER_COORD_EN
   output logic [10:0]                         hcount_out,
   output logic [9:0]                          vcount_out,
`endif
   output logic [1:0]                          state_dbg
);

   localparam int         OUT_WIDTH = IN_WIDTH * BYTES_PER_PIXEL;
   localparam logic [1:0] LAST_IDX  = 2'(BYTES_PER_PIXEL - 1);

   typedef enum logic [1:0] {
      WAIT_FRAME = 2'd0,
      WAIT_LINE  = 2'd1,
      ACTIVE     = 2'd2
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] pclk_sync;
   logic [SYNC_STAGES-1:0] hs_sync;
   logic [SYNC_STAGES-1:0] vs_sync;
   logic [IN_WIDTH-1:0]    data_sync [SYNC_STAGES];

   // Synchronizers preset to 1 so the first cycle after reset never sees a pclk rise.
   always_ff @(posedge clk_pixel_in or posedge rst_in) begin
      if (rst_in) begin
         pclk_sync <= '1;
         hs_sync   <= '1;
         vs_sync   <= '1;
         for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '1;
      end else begin
         pclk_sync    <= {pclk_sync[SYNC_STAGES-2:0], pclk_cam_in};
         hs_sync      <= {hs_sync[SYNC_STAGES-2:0], hs_cam_in};
         vs_sync      <= {vs_sync[SYNC_STAGES-2:0], vs_cam_in};
         data_sync[0] <= data_cam_in;
         for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
      end
   end

   logic                pclk_s, hs_s, vs_s;
   logic [IN_WIDTH-1:0] data_s;
   assign pclk_s = pclk_sync[SYNC_STAGES-1];
   assign hs_s   = hs_sync[SYNC_STAGES-1];
   assign vs_s   = vs_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];

   logic                pclk_prev, edge_r, hs_r, vs_r, hs_prev, vs_prev;
   logic [IN_WIDTH-1:0] data_r;

   // Registered edge detect; hs/vs/data are delayed alongside so all stay aligned.
   always_ff @(posedge clk_pixel_in or posedge rst_in) begin
      if (rst_in) begin
         pclk_prev <= 1'b1;
         edge_r    <= 1'b0;
         hs_r      <= 1'b1;
         vs_r      <= 1'b1;
         hs_prev   <= 1'b1;
         vs_prev   <= 1'b1;
         data_r    <= '0;
      end else begin
         pclk_prev <= pclk_s;
         edge_r    <= pclk_s & ~pclk_prev;
         hs_r      <= hs_s;
         vs_r      <= vs_s;
         hs_prev   <= hs_r;
         vs_prev   <= vs_r;
         data_r    <= data_s;
      end
   end

   logic                 vs_at_edge, frame_pend, line_pend;
   logic [1:0]           byte_idx, cur_idx;
   logic [OUT_WIDTH-1:0] acc, acc_next;
   logic                 hs_fall, vs_fall, vs_rise, qual, take, line_first;

   assign hs_fall    = hs_prev & ~hs_r;
   assign vs_fall    = vs_prev & ~vs_r;
   assign vs_rise    = edge_r & vs_r & ~vs_at_edge;
   assign qual       = edge_r & hs_r & vs_r;
   assign take       = qual & (state != WAIT_FRAME);
   assign cur_idx    = (state == WAIT_LINE) ? 2'd0 : byte_idx;
   assign line_first = (state == WAIT_LINE) | line_pend;
   assign state_dbg  = state;

   // First byte of a pixel lands in the MSBs.
   always_comb begin
      acc_next = acc;
      for (int k = 0; k < BYTES_PER_PIXEL; k++) begin
         if (cur_idx == 2'(k)) acc_next[(BYTES_PER_PIXEL-k)*IN_WIDTH-1 -: IN_WIDTH] = data_r;
      end
   end

   always_ff @(posedge clk_pixel_in or posedge rst_in) begin
      if (rst_in) begin
         state           <= WAIT_FRAME;
         byte_idx        <= 2'd0;
         acc             <= '0;
         data_out        <= '0;
         valid_out       <= 1'b0;
         frame_start_out <= 1'b0;
         line_start_out  <= 1'b0;
         partial_out     <= 1'b0;
         frame_pend      <= 1'b0;
         line_pend       <= 1'b0;
         vs_at_edge      <= 1'b1;
`ifdef CAM_ASSEMBLER_COORD_EN
         hcount_out      <= '0;
         vcount_out      <= '0;
`endif
      end else begin
         valid_out       <= 1'b0;
         frame_start_out <= 1'b0;
         line_start_out  <= 1'b0;
         partial_out     <= 1'b0;
         if (edge_r) vs_at_edge <= vs_r;

         if (take) begin
            acc <= acc_next;
            if (cur_idx == LAST_IDX) begin
               data_out        <= acc_next;
               valid_out       <= 1'b1;
               frame_start_out <= frame_pend;
               line_start_out  <= line_first;
               frame_pend      <= 1'b0;
               line_pend       <= 1'b0;
               byte_idx        <= 2'd0;
`ifdef CAM_ASSEMBLER_COORD_EN
               if (line_first) hcount_out <= '0;
               else if (hcount_out < 11'(HMAX)) hcount_out <= hcount_out + 11'd1;
               if (frame_pend) vcount_out <= '0;
               else if (line_first && (vcount_out < 10'(VMAX))) vcount_out <= vcount_out + 10'd1;
`endif
            end else begin
               byte_idx <= 2'(cur_idx + 2'd1);
               if (state == WAIT_LINE) line_pend <= 1'b1;
            end
         end

         case (state)
            WAIT_FRAME: begin
               byte_idx <= 2'd0;
               if (vs_rise) begin
                  frame_pend <= 1'b1;
                  state      <= WAIT_LINE;
               end
            end
            WAIT_LINE: begin
               if (vs_fall) state <= WAIT_FRAME;
               else if (qual) state <= ACTIVE;
            end
            ACTIVE: begin
               // A falling hs/vs ends the line; any half-built pixel is dropped.
               if (vs_fall || hs_fall) begin
                  partial_out <= (byte_idx != 2'd0);
                  byte_idx    <= 2'd0;
                  line_pend   <= 1'b0;
                  state       <= vs_fall ? WAIT_FRAME : WAIT_LINE;
               end
            end
            default: state <= WAIT_FRAME;
         endcase
      end
   end

endmodule

// File: tb/tb_camera_pixel_assembler.sv
// Bench for camera_pixel_assembler: four parameterisations share one camera stimulus stream,
// each with its own expected-pixel queue and partial-line count.
module tb_camera_pixel_assembler;

   localparam int N_DUT = 4;
   localparam int BPP_OF  [N_DUT] = '{2, 3, 2, 1};
   localparam int SYNC_OF [N_DUT] = '{2, 2, 3, 4};
   localparam int HMAX = 2047;
   localparam int VMAX = 1023;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       pclk = 1'b0;
   logic       hs   = 1'b0;
   logic       vs   = 1'b0;
   logic [7:0] data = 8'h00;

   always #5 clk = ~clk;

   logic [31:0]      dout [N_DUT];
   logic [1:0]       st   [N_DUT];
   logic [N_DUT-1:0] vld, fso, lso, prt;
`ifdef CAM_ASSEMBLER_COORD_EN
   logic [10:0]      hc [N_DUT];
   logic [9:0]       vc [N_DUT];
`endif

   for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
      logic [8*BPP_OF[gi]-1:0] d;
      logic                    v_l, fs_l, ls_l, p_l;
      logic [1:0]              s_l;
`ifdef CAM_ASSEMBLER_COORD_EN
      logic [10:0]             h_l;
      logic [9:0]              vv_l;
      assign hc[gi] = h_l;
      assign vc[gi] = vv_l;
`endif
      camera_pixel_assembler #(
         .IN_WIDTH(8), .BYTES_PER_PIXEL(BPP_OF[gi]), .SYNC_STAGES(SYNC_OF[gi]),
         .HMAX(HMAX), .VMAX(VMAX)
      ) u_dut (
         .clk_pixel_in(clk), .rst_in(rst), .pclk_cam_in(pclk), .hs_cam_in(hs),
         .vs_cam_in(vs), .data_cam_in(data), .data_out(d), .valid_out(v_l),
         .frame_start_out(fs_l), .line_start_out(ls_l), .partial_out(p_l),
`ifdef CAM_ASSEMBLER_COORD_EN
         .hcount_out(h_l), .vcount_out(vv_l),
`endif
         .state_dbg(s_l)
      );
      assign dout[gi] = 32'(d);
      assign vld[gi]  = v_l;
      assign fso[gi]  = fs_l;
      assign lso[gi]  = ls_l;
      assign prt[gi]  = p_l;
      assign st[gi]   = s_l;
   end

   typedef struct packed {
      logic [31:0] data;
      logic        fs;
      logic        ls;
      logic [10:0] h;
      logic [9:0]  v;
   } exp_t;

   exp_t             exp_q [N_DUT][$];
   exp_t             mon_e;
   int               tests = 0;
   int               fails = 0;
   bit               fpend    [N_DUT];
   int               vcur     [N_DUT];
   int               exp_part [N_DUT];
   int               act_part [N_DUT];
   logic [N_DUT-1:0] vld_prev = '0;

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      for (int i = 0; i < N_DUT; i++) begin
         if (prt[i]) act_part[i]++;
         if (vld[i]) begin
            tests++;
            if (vld_prev[i]) begin
               fails++;
               $display("FAIL double_strobe dut%0d: valid_out high two cycles running, required one", i);
            end else if (exp_q[i].size() == 0) begin
               fails++;
               $display("FAIL unexpected_valid dut%0d: data_out=%h, required no strobe", i, dout[i]);
            end else begin
               mon_e = exp_q[i].pop_front();
               if ({dout[i], fso[i], lso[i]} !== {mon_e.data, mon_e.fs, mon_e.ls}) begin
                  fails++;
                  $display("FAIL pixel dut%0d: data=%h fs=%b ls=%b, required data=%h fs=%b ls=%b",
                           i, dout[i], fso[i], lso[i], mon_e.data, mon_e.fs, mon_e.ls);
               end
`ifdef CAM_ASSEMBLER_COORD_EN
               tests++;
               if ({hc[i], vc[i]} !== {mon_e.h, mon_e.v}) begin
                  fails++;
                  $display("FAIL coord dut%0d: h=%0d v=%0d, required h=%0d v=%0d",
                           i, hc[i], vc[i], mon_e.h, mon_e.v);
               end
`endif
            end
         end
      end
      vld_prev = vld;
   end

   // ---------------- model: expected pixels for one line ----------------
   task automatic push_line(input logic [63:0] bv, input int n, input bit count_partial);
      exp_t        e;
      logic [31:0] acc;
      int          cnt, h;
      for (int i = 0; i < N_DUT; i++) begin
         acc = '0; cnt = 0; h = 0;
         for (int j = 0; j < n; j++) begin
            acc = (acc << 8) | 32'(bv[63-8*j -: 8]);
            cnt++;
            if (cnt == BPP_OF[i]) begin
               if (h == 0) vcur[i] = fpend[i] ? 0 : ((vcur[i] + 1 > VMAX) ? VMAX : vcur[i] + 1);
               e.data = acc;
               e.fs   = fpend[i];
               e.ls   = (h == 0);
               e.h    = 11'((h > HMAX) ? HMAX : h);
               e.v    = 10'(vcur[i]);
               exp_q[i].push_back(e);
               fpend[i] = 1'b0;
               h++; acc = '0; cnt = 0;
            end
         end
         if (cnt != 0 && count_partial) exp_part[i]++;
      end
   endtask

   // ---------------- drivers ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      data = b; pclk = 1'b0; cyc(2);
      pclk = 1'b1; cyc(2);
   endtask

   task automatic idle_edges(input int n);
      data = 8'h00;
      repeat (n) begin
         pclk = 1'b0; cyc(2);
         pclk = 1'b1; cyc(2);
      end
   endtask

   task automatic new_frame();
      hs = 1'b0; vs = 1'b0; idle_edges(2);
      vs = 1'b1; idle_edges(2);
      for (int i = 0; i < N_DUT; i++) fpend[i] = 1'b1;
   endtask

   task automatic check_partials(input string tag);
      for (int i = 0; i < N_DUT; i++) begin
         tests++;
         if (act_part[i] != exp_part[i]) begin
            fails++;
            $display("FAIL partial_%s dut%0d: partial pulses=%0d, required %0d", tag, i, act_part[i], exp_part[i]);
         end
      end
   endtask

   task automatic end_line(input string tag);
      pclk = 1'b0; cyc(2);
      hs = 1'b0; idle_edges(2); cyc(8);
      check_partials(tag);
   endtask

   task automatic drive_line(input logic [63:0] bv, input int n, input bit push);
      if (push) push_line(bv, n, 1'b1);
      pclk = 1'b0; hs = 1'b1;
      for (int j = 0; j < n; j++) send_byte(bv[63-8*j -: 8]);
      end_line("line");
   endtask

   task automatic check_reset(input string tag);
      for (int i = 0; i < N_DUT; i++) begin
         tests++;
         if ({dout[i], vld[i], fso[i], lso[i], prt[i], st[i]} !== '0) begin
            fails++;
            $display("FAIL reset_%s dut%0d: data=%h valid=%b fs=%b ls=%b partial=%b state=%0d, required all 0",
                     tag, i, dout[i], vld[i], fso[i], lso[i], prt[i], st[i]);
         end
`ifdef CAM_ASSEMBLER_COORD_EN
         tests++;
         if ({hc[i], vc[i]} !== '0) begin
            fails++;
            $display("FAIL reset_coord_%s dut%0d: h=%0d v=%0d, required 0", tag, i, hc[i], vc[i]);
         end
`endif
      end
   endtask

   task automatic check_drained(input string tag);
      for (int i = 0; i < N_DUT; i++) begin
         tests++;
         if (exp_q[i].size() != 0) begin
            fails++;
            $display("FAIL drain_%s dut%0d: %0d pixels never produced, required 0", tag, i, exp_q[i].size());
         end
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit          nf;
      int          n;
      logic [63:0] bv;
      int          exp_partial_a;
   } vec_t;

   vec_t vecs [8];
   int   lat  [N_DUT];
   int   exp_lat [N_DUT];
   int   part_a0;

   initial begin
      vecs[0] = '{1'b1, 4, 64'hA1B2C3D4_00000000, 0};
      vecs[1] = '{1'b0, 7, 64'h01020304_05060700, 1};
      vecs[2] = '{1'b0, 3, 64'h102030_0000000000, 1};
      vecs[3] = '{1'b0, 6, 64'h9A8B7C6D_5E4F0000, 0};
      vecs[4] = '{1'b1, 8, 64'h11121314_15161718, 0};
      vecs[5] = '{1'b0, 8, 64'h21222324_25262728, 0};
      vecs[6] = '{1'b0, 8, 64'h31323334_35363738, 0};
      vecs[7] = '{1'b1, 2, 64'h4142_000000000000, 0};
      exp_lat = '{4, 0, 5, 6};
      for (int i = 0; i < N_DUT; i++) begin
         fpend[i] = 1'b0; vcur[i] = 0; exp_part[i] = 0; act_part[i] = 0;
      end

      // clock / reset
      rst = 1'b1; cyc(3);
      check_reset("initial");
      rst = 1'b0; cyc(3);

      // table-driven lines
      for (int t = 0; t < 8; t++) begin
         part_a0 = act_part[0];
         if (vecs[t].nf) new_frame();
         drive_line(vecs[t].bv, vecs[t].n, 1'b1);
         tests++;
         if (act_part[0] - part_a0 != vecs[t].exp_partial_a) begin
            fails++;
            $display("FAIL vec%0d_partial_a: partial pulses=%0d, required %0d",
                     t, act_part[0] - part_a0, vecs[t].exp_partial_a);
         end
      end
      check_drained("table");

      // pclk rise coinciding with the hs fall is end of line, not data
      push_line(64'h5A6B_000000000000, 2, 1'b1);
      pclk = 1'b0; hs = 1'b1;
      send_byte(8'h5A); send_byte(8'h6B);
      data = 8'hEE; pclk = 1'b0; cyc(2);
      pclk = 1'b1; hs = 1'b0; cyc(2);
      idle_edges(2); cyc(8);
      check_partials("hs_edge");

      // latency from a single pclk rise to valid_out
      push_line(64'h1122_000000000000, 2, 1'b1);
      pclk = 1'b0; hs = 1'b1;
      send_byte(8'h11);
      pclk = 1'b0; data = 8'h22; cyc(6);
      pclk = 1'b1;
      for (int i = 0; i < N_DUT; i++) lat[i] = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         @(negedge clk);
         for (int i = 0; i < N_DUT; i++) if (vld[i] && lat[i] == 0) lat[i] = k;
      end
      for (int i = 0; i < N_DUT; i++) begin
         tests++;
         if (lat[i] != exp_lat[i]) begin
            fails++;
            $display("FAIL latency dut%0d: %0d cycles, required %0d", i, lat[i], exp_lat[i]);
         end
      end
      cyc(1);
      end_line("latency");

      // reset mid-line: nothing until the next frame
      new_frame();
      push_line(64'h3132_000000000000, 2, 1'b0);
      pclk = 1'b0; hs = 1'b1;
      send_byte(8'h31); send_byte(8'h32);
      cyc(10);
      check_drained("pre_reset");
      rst = 1'b1; cyc(1);
      check_reset("midline");
      rst = 1'b0;
      for (int i = 0; i < N_DUT; i++) fpend[i] = 1'b0;
      send_byte(8'h33); send_byte(8'h34);
      end_line("post_reset");
      drive_line(64'h41424344_00000000, 4, 1'b0);
      new_frame();
      drive_line(64'h51525354_00000000, 4, 1'b1);

      cyc(20);
      check_drained("final");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit, required completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/camera_pixel_assembler.md
CAMERA_PIXEL_ASSEMBLER -- requirements
Module: camera_pixel_assembler

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 8: width of the camera data bus.
REQ-002 SHALL have parameter BYTES_PER_PIXEL, default 2, legal range 1..4: number of bus words packed into one pixel.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, legal range 2..4: synchronizer depth applied to pclk_cam_in, hs_cam_in, vs_cam_in and data_cam_in.
REQ-004 SHALL have parameter HMAX, default 2047, and parameter VMAX, default 1023: saturation limits for the pixel coordinates.
REQ-005 SHALL have port clk_pixel_in, input, width 1: the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_in, input, width 1: asynchronous, active-high reset.
REQ-007 SHALL have ports pclk_cam_in, hs_cam_in and vs_cam_in, each input, width 1: raw camera pixel clock, line-valid and frame-valid.
REQ-008 SHALL have port data_cam_in, input, width IN_WIDTH: raw camera data.
REQ-009 SHALL have port data_out, output, width IN_WIDTH*BYTES_PER_PIXEL: assembled pixel.
REQ-010 SHALL have port valid_out, output, width 1: one-cycle strobe marking data_out as a new pixel.
REQ-011 SHALL have ports frame_start_out and line_start_out, each output, width 1: qualifiers of valid_out.
REQ-012 SHALL have port partial_out, output, width 1: one-cycle error pulse for a line that ends mid-pixel.

Function
REQ-013 SHALL pass pclk, hs, vs and data through SYNC_STAGES flops and detect a pclk rising edge as synced pclk high with the previous synced pclk low.
REQ-014 SHALL sample synced data only on a detected edge, and only when synced hs and synced vs are both high.
REQ-015 SHALL implement states WAIT_FRAME, WAIT_LINE and ACTIVE.
REQ-016 WAIT_FRAME SHALL go to WAIT_LINE on a detected edge where synced vs is high and was low at the previous edge.
REQ-017 WAIT_LINE SHALL go to ACTIVE on the first qualifying edge, which is the first byte of the line.
REQ-018 ACTIVE SHALL go to WAIT_LINE when hs falls, and to WAIT_FRAME when vs falls.
REQ-019 SHALL hold a byte index, 0..BYTES_PER_PIXEL-1, forced to 0 on every line start.
REQ-020 SHALL write byte index k to data_out bits [(BYTES_PER_PIXEL-k)*IN_WIDTH-1 -: IN_WIDTH], so the first byte lands in the MSBs.
REQ-021 On sampling index BYTES_PER_PIXEL-1, SHALL assert valid_out for exactly one clk_pixel_in cycle, in the cycle after the edge-detect cycle, and SHALL wrap the index to 0.
REQ-022 data_out SHALL hold its value between valid_out strobes.
REQ-023 With BYTES_PER_PIXEL=1, every qualifying edge SHALL produce valid_out.
REQ-024 SHALL assert line_start_out with the first valid_out of each line.
REQ-025 SHALL assert frame_start_out with the first valid_out after a vs rise.
REQ-026 If hs or vs falls while the byte index is nonzero, SHALL pulse partial_out for one cycle, discard the partial pixel (no valid_out), and clear the index.
REQ-027 Latency SHALL be SYNC_STAGES+2 clk_pixel_in cycles from a pclk_cam_in rise to the matching valid_out.
REQ-028 A pclk edge coinciding with an hs fall SHALL be treated as end of line, not as data.

Reset
REQ-029 While rst_in is high, the block SHALL asynchronously force state WAIT_FRAME, byte index 0, data_out 0, and valid_out, frame_start_out, line_start_out, partial_out and any coordinate outputs to 0.
REQ-030 During reset, the synchronizer flops and the previous-pclk flop SHALL be forced to 1, so no edge is detected in the first cycle after release.
REQ-031 After a reset asserted mid-frame, no valid_out SHALL occur until the next vs rise.

Configuration
REQ-032 With macro CAM_ASSEMBLER_COORD_EN defined, the block SHALL add output ports hcount_out (11 bits) and vcount_out (10 bits), both updated with valid_out.
REQ-033 With CAM_ASSEMBLER_COORD_EN defined: hcount_out is 0 at line start and increments per pixel; vcount_out is 0 for the first line of a frame and increments per line; both saturate at HMAX and VMAX.
REQ-034 Without CAM_ASSEMBLER_COORD_EN, these ports and their counters SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-035 Defaults; one line of bytes 0xA1,0xB2,0xC3,0xD4 -> valid_out twice, data_out 0xA1B2 then 0xC3D4, first strobe with line_start_out=1 and frame_start_out=1.
REQ-036 BYTES_PER_PIXEL=3; 7 bytes in one line -> two pixels, then partial_out=1 at the hs fall, with no third valid_out.
REQ-037 SYNC_STAGES=3; single pclk rise -> valid_out exactly 5 cycles later, and pclk at 1/4 clk rate never yields a double strobe.
REQ-038 rst_in pulsed mid-line of frame 1 -> no valid_out until frame 2, whose first pixel has frame_start_out=1.
REQ-039 CAM_ASSEMBLER_COORD_EN defined; 3 lines of 4 pixels -> last pixel reports hcount_out=3 and vcount_out=2, and a new vs rise resets vcount_out to 0.
